// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline payload types and helpers for RV32IM stage boundaries.
// Stage registers size themselves with WIDTH = $bits(<typedef>).
package rv_pipe_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [5:0]      op;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] st_data;
        logic [4:0]      rd;
        logic            mem_rd;
        logic            mem_wr;
        logic            wb_en;
    } ex_mem_t;

    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_en_reg.sv
// Enabled data register with synchronous active-high reset to RESET_VAL.
// Ports: clk, reset, en (load strobe), d (next value), q (held value).
module en_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with valid/ready, flush and optional skid entry.
// Ports: clk, reset, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy.
module pipe_stage_skid
    import rv_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid_q;
    logic             main_valid_d;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_count(main_valid_q, skid_valid);

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
        end
    end

    if (SKID_EN) begin : g_skid
        logic             skid_valid_q;
        logic             skid_valid_d;
        logic             skid_en;
        logic [WIDTH-1:0] skid_q;

        en_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk   (clk),
            .reset (reset),
            .en    (skid_en),
            .d     (in_data),
            .q     (skid_q)
        );

        // Ready depends only on the skid flop, never on out_ready.
        assign in_ready   = ~skid_valid_q & ~reset;
        assign skid_valid = skid_valid_q;

        always_comb begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
            main_en      = 1'b0;
            skid_en      = 1'b0;
            main_d       = in_data;
            if (flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else if (~main_valid_q | out_fire) begin
                // Skid beat is older than anything arriving now.
                if (skid_valid_q) begin
                    main_en      = 1'b1;
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_en      = 1'b1;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_en      = 1'b1;
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                skid_valid_q <= 1'b0;
            end else begin
                skid_valid_q <= skid_valid_d;
            end
        end
    end else begin : g_noskid
        assign in_ready   = (~main_valid_q | out_ready) & ~reset;
        assign skid_valid = 1'b0;

        always_comb begin
            main_valid_d = main_valid_q;
            main_en      = 1'b0;
            main_d       = in_data;
            if (flush) begin
                main_valid_d = 1'b0;
            end else if (in_fire) begin
                main_en      = 1'b1;
                main_valid_d = 1'b1;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end
    end

endmodule
